// File: rtl/rte_pkg.sv
// Shared definitions for the emulated-clock generator: address space and FSM encoding.
package rte_pkg;

  localparam int unsigned NUM_ADDR = 32;
  localparam int unsigned ADDR_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/clk_gen_regfile.sv
// Per-address half-period, step counter and clock-value storage.
// One combinational read port at the scan index and one write port.
// Optional macro CLK_GEN_DEBUG_EN exposes the clock-value vector.
module clk_gen_regfile
  import rte_pkg::*;
#(
  parameter int unsigned HP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [HP_W-1:0]   rd_hp_c,
  output logic [HP_W-1:0]   rd_cnt_c,
  output logic              rd_clk_c,
  input  logic              we,
  input  logic              we_hp,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [HP_W-1:0]   wr_hp,
  input  logic [HP_W-1:0]   wr_cnt,
  input  logic              wr_clk
`ifdef CLK_GEN_DEBUG_EN
  ,
  output logic [NUM_ADDR-1:0] db_clk_state
`endif
);

  logic [HP_W-1:0]     hp_q  [NUM_ADDR];
  logic [HP_W-1:0]     cnt_q [NUM_ADDR];
  logic [NUM_ADDR-1:0] clk_state_q;

  // Single write port; half-period is only rewritten by configuration writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_ADDR; i++) begin
        hp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      clk_state_q <= '0;
    end else if (we) begin
      if (we_hp) begin
        hp_q[wr_addr] <= wr_hp;
      end
      cnt_q[wr_addr]       <= wr_cnt;
      clk_state_q[wr_addr] <= wr_clk;
    end
  end

  assign rd_hp_c  = hp_q[rd_addr];
  assign rd_cnt_c = cnt_q[rd_addr];
  assign rd_clk_c = clk_state_q[rd_addr];

`ifdef CLK_GEN_DEBUG_EN
  assign db_clk_state = clk_state_q;
`endif

endmodule

// File: rtl/clock_gen_module.sv
// Emulated clock generator: per step, pulses the input load, then walks all
// addresses and writes the updated clock value of each flagged address.
// Optional macro CLK_GEN_DEBUG_EN adds db_clk_state / db_fsm_state outputs.
module clock_gen_module
  import rte_pkg::*;
#(
  parameter int unsigned HP_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [NUM_ADDR-1:0] cfg_clk_flags,
  input  logic                cfg_wr_en,
  input  logic [ADDR_W-1:0]   cfg_wr_addr,
  input  logic [HP_W-1:0]     cfg_half_period,
  output logic                en_load_input,
  output logic                en_wr_input,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic                val,
  output logic                busy,
  output logic                done
`ifdef CLK_GEN_DEBUG_EN
  ,
  output logic [NUM_ADDR-1:0] db_clk_state,
  output logic [1:0]          db_fsm_state
`endif
);

  fsm_state_e          state_q, state_d;
  logic [NUM_ADDR-1:0] flags_q, flags_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;

  logic                load_d, wr_en_d, val_d, done_d, busy_d;
  logic [ADDR_W-1:0]   wr_addr_d;

  logic [HP_W-1:0]     rd_hp, rd_cnt;
  logic                rd_clk;
  logic                rf_we, rf_we_hp, rf_clk;
  logic [ADDR_W-1:0]   rf_addr;
  logic [HP_W-1:0]     rf_hp, rf_cnt;

  clk_gen_regfile #(.HP_W(HP_W)) u_regfile (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_addr      (idx_q),
    .rd_hp_c      (rd_hp),
    .rd_cnt_c     (rd_cnt),
    .rd_clk_c     (rd_clk),
    .we           (rf_we),
    .we_hp        (rf_we_hp),
    .wr_addr      (rf_addr),
    .wr_hp        (rf_hp),
    .wr_cnt       (rf_cnt),
    .wr_clk       (rf_clk)
`ifdef CLK_GEN_DEBUG_EN
    ,
    .db_clk_state (db_clk_state)
`endif
  );

  // Next-state, register-file write port mux and next output values
  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    idx_d     = idx_q;
    load_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    val_d     = 1'b0;
    done_d    = 1'b0;
    busy_d    = (state_q != ST_IDLE);
    rf_we     = 1'b0;
    rf_we_hp  = 1'b0;
    rf_addr   = idx_q;
    rf_hp     = rd_hp;
    rf_cnt    = rd_cnt;
    rf_clk    = rd_clk;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_wr_en) begin
          rf_we    = 1'b1;
          rf_we_hp = 1'b1;
          rf_addr  = cfg_wr_addr;
          rf_hp    = cfg_half_period;
          rf_cnt   = cfg_half_period;
          rf_clk   = 1'b0;
        end
        if (start) begin
          flags_d = cfg_clk_flags;
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_d  = 1'b1;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        wr_addr_d = idx_q;
        if (flags_q[idx_q]) begin
          rf_we = 1'b1;
          if (rd_cnt == '0) begin
            rf_clk = ~rd_clk;
            rf_cnt = rd_hp;
          end else begin
            rf_cnt = rd_cnt - HP_W'(1);
          end
          wr_en_d = 1'b1;
          val_d   = rf_clk;
        end
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(NUM_ADDR - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      flags_q       <= '0;
      idx_q         <= '0;
      en_load_input <= 1'b0;
      en_wr_input   <= 1'b0;
      wr_addr       <= '0;
      val           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      flags_q       <= flags_d;
      idx_q         <= idx_d;
      en_load_input <= load_d;
      en_wr_input   <= wr_en_d;
      wr_addr       <= wr_addr_d;
      val           <= val_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

`ifdef CLK_GEN_DEBUG_EN
  assign db_fsm_state = 2'(state_q);
`endif

endmodule

// File: tb/tb_clock_gen_module.sv
// Self-checking bench for clock_gen_module: step-level model plus directed vectors.
module tb_clock_gen_module;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] cfg_clk_flags;
  logic        cfg_wr_en;
  logic [4:0]  cfg_wr_addr;
  logic [7:0]  cfg_half_period;
  logic        en_load_input;
  logic        en_wr_input;
  logic [4:0]  wr_addr;
  logic        val;
  logic        busy;
  logic        done;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_on = 1'b0;

  clock_gen_module #(.HP_W(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .cfg_clk_flags   (cfg_clk_flags),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_wr_addr     (cfg_wr_addr),
    .cfg_half_period (cfg_half_period),
    .en_load_input   (en_load_input),
    .en_wr_input     (en_wr_input),
    .wr_addr         (wr_addr),
    .val             (val),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_b(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_i(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Step-level model: a clock with half-period hp, advanced s steps since its
  // last configuration, reads floor(s/(hp+1)) mod 2.
  int hp_m    [32];
  int steps_m [32];
  bit exp_en  [32];
  bit exp_val [32];
  int k_m = -1;  // cycles since the accepted start edge, -1 when idle

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_m = -1;
      for (int i = 0; i < 32; i++) begin
        hp_m[i]    = 0;
        steps_m[i] = 0;
        exp_en[i]  = 1'b0;
        exp_val[i] = 1'b0;
      end
    end else if (k_m == -1 || k_m == 34) begin
      if (cfg_wr_en) begin
        hp_m[cfg_wr_addr]    = int'(cfg_half_period);
        steps_m[cfg_wr_addr] = 0;
      end
      if (start) begin
        for (int a = 0; a < 32; a++) begin
          exp_en[a] = cfg_clk_flags[a];
          if (cfg_clk_flags[a]) begin
            steps_m[a] = steps_m[a] + 1;
            exp_val[a] = ((steps_m[a] / (hp_m[a] + 1)) % 2) != 0;
          end
        end
        k_m = 0;
      end else begin
        k_m = -1;
      end
    end else begin
      k_m = k_m + 1;
    end
  end

  // Cycle-by-cycle comparison of every output against the model timeline
  always @(negedge clk) begin
    int  a;
    bit  in_scan;
    bit  e_wr;
    if (chk_on) begin
      in_scan = (k_m >= 2) && (k_m <= 33);
      a       = in_scan ? (k_m - 2) : 0;
      e_wr    = in_scan && exp_en[a];
      check_b("en_load_input", en_load_input, k_m == 1);
      check_b("en_wr_input", en_wr_input, e_wr);
      check_i("wr_addr", int'(wr_addr), a);
      check_b("val", val, e_wr && exp_val[a]);
      check_b("busy", busy, k_m >= 1);
      check_b("done", done, k_m == 34);
      check_b("load_wr_overlap", en_load_input & en_wr_input, 1'b0);
    end
  end

  // Observations collected by run_step for literal checks
  logic obs_val [32];
  int   obs_k   [32];
  int   n_wr, n_load, n_overlap, done_k;

  task automatic cfg_write(input logic [4:0] a, input logic [7:0] hp);
    @(negedge clk);
    cfg_wr_en       = 1'b1;
    cfg_wr_addr     = a;
    cfg_half_period = hp;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic run_step(input logic [31:0] flags, input bit inj, input bit chg,
                          input bit sim_cfg, input int rst_at);
    for (int i = 0; i < 32; i++) begin
      obs_val[i] = 1'b0;
      obs_k[i]   = -1;
    end
    n_wr = 0; n_load = 0; n_overlap = 0; done_k = -1;
    @(negedge clk);
    start         = 1'b1;
    cfg_clk_flags = flags;
    if (sim_cfg) begin
      cfg_wr_en       = 1'b1;
      cfg_wr_addr     = 5'd31;
      cfg_half_period = 8'd3;
    end
    @(posedge clk);
    #1;
    start     = 1'b0;
    cfg_wr_en = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      start     = 1'b0;
      cfg_wr_en = 1'b0;
      if (k == rst_at) begin
        check_i("rst_scan_idx", int'(wr_addr), 10);
        reset_n = 1'b0;
        break;
      end
      if (en_load_input) n_load++;
      if (done) done_k = k;
      if (en_wr_input) begin
        n_wr++;
        obs_val[wr_addr] = val;
        obs_k[wr_addr]   = k;
      end
      if (en_load_input && en_wr_input) n_overlap++;
      if (k == 3 && chg) cfg_clk_flags = '0;
      if (k == 5 && inj) begin
        start           = 1'b1;
        cfg_wr_en       = 1'b1;
        cfg_wr_addr     = 5'd0;
        cfg_half_period = 8'd7;
      end
    end
  endtask

  logic exp0 [6];
  logic exp2 [6];
  int   n_done_after;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp0 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp2 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    reset_n         = 1'b1;
    start           = 1'b0;
    cfg_clk_flags   = '0;
    cfg_wr_en       = 1'b0;
    cfg_wr_addr     = '0;
    cfg_half_period = '0;
    #3;
    reset_n = 1'b0;
    chk_on  = 1'b1;
    repeat (3) @(negedge clk);
    check_b("reset_busy", busy, 1'b0);
    check_b("reset_done", done, 1'b0);
    check_b("reset_en_load", en_load_input, 1'b0);
    reset_n = 1'b1;

    // Basic step, ignored strobes and six consecutive periods
    cfg_write(5'd0, 8'd0);
    cfg_write(5'd2, 8'd1);
    for (int s = 0; s < 6; s++) begin
      run_step(32'h0000_0005, s == 0, 1'b0, 1'b0, 0);
      check_i("basic_n_load", n_load, 1);
      check_i("basic_done_k", done_k, 34);
      check_i("basic_n_wr", n_wr, 2);
      check_i("addr0_k", obs_k[0], 2);
      check_i("addr2_k", obs_k[2], 4);
      check_b("addr0_val", obs_val[0], exp0[s]);
      check_b("addr2_val", obs_val[2], exp2[s]);
    end

    // Start together with a config write to address 31
    run_step(32'h8000_0005, 1'b0, 1'b0, 1'b1, 0);
    check_i("sim_addr31_k", obs_k[31], 33);
    check_b("sim_addr31_val", obs_val[31], 1'b0);
    check_b("sim_addr0_val", obs_val[0], 1'b1);
    check_b("sim_addr2_val", obs_val[2], 1'b1);
    check_i("sim_n_wr", n_wr, 3);
    run_step(32'h8000_0000, 1'b0, 1'b0, 1'b0, 0);
    check_b("sim2_addr31_val", obs_val[31], 1'b0);

    // Flags snapshot: changing the flags mid-step has no effect
    run_step(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
    check_i("snap_n_wr", n_wr, 32);
    check_i("snap_overlap", n_overlap, 0);
    check_i("snap_done_k", done_k, 34);

    // Reset mid-scan at index 10
    run_step(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 12);
    #1;
    check_b("rst_en_wr", en_wr_input, 1'b0);
    check_i("rst_wr_addr", int'(wr_addr), 0);
    check_b("rst_busy_now", busy, 1'b0);
    @(posedge clk);
    #1;
    check_b("rst_busy_next", busy, 1'b0);
    check_b("rst_val_next", val, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    n_done_after = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) n_done_after++;
    end
    check_i("rst_no_done", n_done_after, 0);
    check_b("rst_idle_busy", busy, 1'b0);

    // After reset every half-period is zero, so both clocks read 1
    run_step(32'h0000_0005, 1'b0, 1'b0, 1'b0, 0);
    check_b("post_rst_addr0", obs_val[0], 1'b1);
    check_b("post_rst_addr2", obs_val[2], 1'b1);
    check_i("post_rst_done_k", done_k, 34);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
